// File: rtl/apb_ram_pkg.sv
// apb_ram_pkg: shared types and constants for the apb_ram_slave_wait slice.
package apb_ram_pkg;

  // Slave transfer state
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Wait-state counter width; supports 0..15 inserted cycles
  localparam int WAIT_W = 4;

  // PSLVERR response encodings
  localparam logic PSLVERR_OK  = 1'b0;
  localparam logic PSLVERR_ERR = 1'b1;

endpackage

// File: rtl/apb_ram_mem.sv
// apb_ram_mem: DEPTH x DATA_WIDTH storage with a registered read port and a
// byte-enabled synchronous write port. Contents are never cleared by reset.
module apb_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    rd_clr,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; only lanes with an asserted enable change
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_en && wr_be[b]) begin
        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Registered read; rd_clr forces zero so out-of-range reads never touch the array
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_clr ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/apb_ram_slave_wait.sv
// apb_ram_slave_wait: APB3 slave RAM with programmable wait states, PSLVERR on
// out-of-range word addresses and a registered read path.
// Optional byte strobes: define APB_RAM_PSTRB_EN to add the PSTRB port.
module apb_ram_slave_wait
  import apb_ram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit lets DEPTH == 2**ADDR_WIDTH compare without overflow (err then never fires)
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_W-1:0]   WAIT_INIT = WAIT_W'(WAIT_STATES);

  state_t                state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wr_be;

  logic setup;
  logic addr_err;
  logic complete;
  logic rd_en;
  logic wr_en;

  // Handshake decode; PREADY/PSLVERR depend only on registered state
  always_comb begin
    setup    = (state == IDLE) && PSEL && !PENABLE;
    addr_err = ({1'b0, PADDR} >= DEPTH_EXT);
    PREADY   = (state == ACCESS) && (wait_cnt == '0);
    PSLVERR  = (PREADY && err_q) ? PSLVERR_ERR : PSLVERR_OK;
    complete = PREADY && PSEL && PENABLE;
    wr_en    = complete && write_q && !err_q && !PRESET;
    rd_en    = setup && !PWRITE && !PRESET;
  end

`ifdef APB_RAM_PSTRB_EN
  logic [NB-1:0] strb_q;

  // Strobes are captured with the rest of the setup phase
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      strb_q <= '0;
    end else if (setup) begin
      strb_q <= PSTRB;
    end
  end

  assign wr_be = strb_q;
`else
  assign wr_be = '1;
`endif

  // Transfer FSM: capture on setup, count wait states, finish or abort
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state    <= ACCESS;
            wait_cnt <= WAIT_INIT;
            idx_q    <= PADDR[IDX_W-1:0];
            write_q  <= PWRITE;
            err_q    <= addr_err;
            wdata_q  <= PWDATA;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (PENABLE) begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .rd_en   (rd_en),
    .rd_clr  (addr_err),
    .rd_idx  (PADDR[IDX_W-1:0]),
    .rd_data (PRDATA),
    .wr_en   (wr_en),
    .wr_be   (wr_be),
    .wr_idx  (idx_q),
    .wr_data (wdata_q)
  );

endmodule

// File: tb/tb_apb_ram_slave_wait.sv
// Directed bench for apb_ram_slave_wait: three instances (0, 3 and 2 wait
// states) share the APB bus and are selected individually.
module tb_apb_ram_slave_wait;

  logic        PCLK;
  logic        PRESET;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
`ifdef APB_RAM_PSTRB_EN
  logic [3:0]  pstrb;
`endif

  int vectors = 0;
  int errs    = 0;

  logic [31:0] r_first, r_data;
  logic        r_err, r_err_early;
  int          r_waits;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_ram_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(0)) u_w0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_RAM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_ram_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_w3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_RAM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_ram_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(2)) u_w2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_RAM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer on instance s; access phase bounded to 20 cycles
  task automatic xfer(input int s, input logic w, input logic [7:0] a, input logic [31:0] d);
    bit done;
    done        = 1'b0;
    r_waits     = 0;
    r_err       = 1'b0;
    r_err_early = 1'b0;
    r_data      = '0;
    psel[s] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = w;
    PADDR   = a;
    PWDATA  = d;
    step();
    PENABLE = 1'b1;
    r_first = prdata[s];
    for (int i = 0; i < 20 && !done; i++) begin
      if (pready[s]) begin
        r_data = prdata[s];
        r_err  = pslverr[s];
        done   = 1'b1;
      end else begin
        r_waits++;
        if (pslverr[s]) r_err_early = 1'b1;
      end
      step();
    end
    psel[s] = 1'b0;
    PENABLE = 1'b0;
    check("pready_seen", 32'(done), 32'd1);
  endtask

  task automatic do_write(input int s, input logic [7:0] a, input logic [31:0] d,
                          input logic exp_err, input int exp_waits, input string tag);
    xfer(s, 1'b1, a, d);
    check({tag, ".waits"}, 32'(r_waits), 32'(exp_waits));
    check({tag, ".pslverr"}, 32'(r_err), 32'(exp_err));
    check({tag, ".err_early"}, 32'(r_err_early), 32'd0);
  endtask

  task automatic do_read(input int s, input logic [7:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input int exp_waits, input string tag);
`ifdef APB_RAM_PSTRB_EN
    pstrb = 4'b0000;
`endif
    xfer(s, 1'b0, a, 32'h0);
    check({tag, ".waits"}, 32'(r_waits), 32'(exp_waits));
    check({tag, ".pslverr"}, 32'(r_err), 32'(exp_err));
    check({tag, ".err_early"}, 32'(r_err_early), 32'd0);
    check({tag, ".first"}, r_first, exp_d);
    check({tag, ".prdata"}, r_data, exp_d);
  endtask

  initial begin
    PRESET  = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
`ifdef APB_RAM_PSTRB_EN
    pstrb = 4'b1111;
`endif

    // Reset for two cycles, then idle
    step();
    step();
    PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.pready%0d", i), 32'(pready[i]), 32'd0);
      check($sformatf("rst.pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      check($sformatf("rst.prdata%0d", i), prdata[i], 32'd0);
    end
    step();
    step();
    check("idle.pready", 32'(pready[0]), 32'd0);
    check("idle.prdata", prdata[0], 32'd0);

    // PENABLE without a setup phase is ignored
    PENABLE = 1'b1;
    psel[0] = 1'b1;
    PADDR   = 8'd5;
    step();
    check("noset.pready", 32'(pready[0]), 32'd0);
    step();
    check("noset.pready2", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0;
    PENABLE = 1'b0;
    step();

    // Zero wait states: write then read back
    do_write(0, 8'd5, 32'hDEADBEEF, 1'b0, 0, "w0.wr5");
    do_read (0, 8'd5, 32'hDEADBEEF, 1'b0, 0, "w0.rd5");
    do_write(0, 8'd6, 32'h01020304, 1'b0, 0, "w0.wr6");
    check("w0.prdata_hold", prdata[0], 32'hDEADBEEF);
    do_read (0, 8'd6, 32'h01020304, 1'b0, 0, "w0.rd6");

    // Three wait states, back to back
    do_write(1, 8'd5, 32'hDEADBEEF, 1'b0, 3, "w3.wr5");
    do_read (1, 8'd5, 32'hDEADBEEF, 1'b0, 3, "w3.rd5");

    // Out-of-range accesses; index 64 aliases to 0 if not blocked
    do_write(0, 8'd0,  32'hA5A5A5A5, 1'b0, 0, "oor.pre0");
    do_write(0, 8'd63, 32'h5A5A5A5A, 1'b0, 0, "oor.pre63");
    do_write(0, 8'd64, 32'h00001234, 1'b1, 0, "oor.wr64");
    do_read (0, 8'd64, 32'h00000000, 1'b1, 0, "oor.rd64");
    do_read (0, 8'd0,  32'hA5A5A5A5, 1'b0, 0, "oor.rd0");
    do_read (0, 8'd63, 32'h5A5A5A5A, 1'b0, 0, "oor.rd63");
    do_read (0, 8'd255, 32'h00000000, 1'b1, 0, "oor.rd255");
    do_write(1, 8'd128, 32'hFFFFFFFF, 1'b1, 3, "oor.w3wr128");

`ifdef APB_RAM_PSTRB_EN
    // Byte strobes
    pstrb = 4'b1111;
    do_write(0, 8'd7, 32'hAABBCCDD, 1'b0, 0, "strb.full");
    pstrb = 4'b0101;
    do_write(0, 8'd7, 32'h11223344, 1'b0, 0, "strb.0101");
    do_read (0, 8'd7, 32'hAA22CC44, 1'b0, 0, "strb.rd");
    pstrb = 4'b0000;
    do_write(0, 8'd7, 32'h99999999, 1'b0, 0, "strb.none");
    do_read (0, 8'd7, 32'hAA22CC44, 1'b0, 0, "strb.rd2");
    pstrb = 4'b1111;
`else
    do_write(0, 8'd7, 32'hAABBCCDD, 1'b0, 0, "nostrb.wr");
    do_write(0, 8'd7, 32'h11223344, 1'b0, 0, "nostrb.wr2");
    do_read (0, 8'd7, 32'h11223344, 1'b0, 0, "nostrb.rd");
`endif

    // Abort: drop PSEL in the second access cycle of a two-wait write
    do_write(2, 8'd9, 32'h600DF00D, 1'b0, 2, "abort.pre");
    psel[2] = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 8'd9;
    PWDATA  = 32'hBAD0BAD0;
    step();
    PENABLE = 1'b1;
    step();
    psel[2] = 1'b0;
    step();
    check("abort.pready", 32'(pready[2]), 32'd0);
    PENABLE = 1'b0;
    step();
    do_read(2, 8'd9, 32'h600DF00D, 1'b0, 2, "abort.rd9");

    // Reset mid-access on the two-wait instance
    psel[2] = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 8'd9;
    PWDATA  = 32'hBAD1BAD1;
    step();
    PENABLE = 1'b1;
    step();
    PRESET = 1'b1;
    step();
    check("rstmid.pready", 32'(pready[2]), 32'd0);
    check("rstmid.prdata", prdata[2], 32'd0);
    PRESET  = 1'b0;
    psel[2] = 1'b0;
    PENABLE = 1'b0;
    step();
    do_read(2, 8'd9, 32'h600DF00D, 1'b0, 2, "rstmid.rd9");

    // Reset on the completion edge of a zero-wait write blocks the commit
    psel[0] = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 8'd5;
    PWDATA  = 32'hBADBAD00;
    step();
    check("rstdone.pready_before", 32'(pready[0]), 32'd1);
    PENABLE = 1'b1;
    PRESET  = 1'b1;
    step();
    check("rstdone.pready", 32'(pready[0]), 32'd0);
    PRESET  = 1'b0;
    psel[0] = 1'b0;
    PENABLE = 1'b0;
    step();
    do_read(0, 8'd5, 32'hDEADBEEF, 1'b0, 0, "rstdone.rd5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
